// File: rtl/hold_arbiter.sv
// ============================================================================
// hold_arbiter: two-requester round-robin arbiter for the 8088 HOLD/HLDA bus
// handshake, with hold-time preemption and HLDA-loss error reporting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hold_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic hlda_i,
  output logic hold_o,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic owner_o,
  output logic err_o
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t     state_q;
  logic       owner_q;
  logic       prio_q;
  logic [7:0] cnt_q;
  logic       hold_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       err_q;

  logic own_req_d;
  logic oth_req_d;
  logic winner_d;

  always_comb begin
    own_req_d = owner_q ? req1_i : req0_i;
    oth_req_d = owner_q ? req0_i : req1_i;
    // prio_q names the requester that wins a tie.
    winner_d  = (req0_i & req1_i) ? prio_q : req1_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= 8'd0;
      hold_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0_i | req1_i) begin
            owner_q <= winner_d;
            hold_q  <= 1'b1;
            state_q <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (!own_req_d) begin
            hold_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else if (hlda_i) begin
            gnt0_q  <= ~owner_q;
            gnt1_q  <= owner_q;
            cnt_q   <= 8'd0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!hlda_i) begin
            // Processor took the bus back under us: abort without a RELEASE.
            hold_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (!own_req_d || ((cnt_q == HOLD_MAX) && oth_req_d)) begin
            hold_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else if (cnt_q != HOLD_MAX) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RELEASE: begin
          if (!hlda_i) begin
            prio_q  <= ~owner_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hold_o  = hold_q;
  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign owner_o = owner_q;
  assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hold_arbiter.sv
// ============================================================================
// tb_hold_arbiter: randomized scoreboard bench for hold_arbiter with a
// transaction-level reference model and a behavioural 8088 HLDA responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hold_arbiter;

  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, hlda = 1'b0;
  logic hold_o, gnt0_o, gnt1_o, owner_o, err_o;

  always #5 clk = ~clk;

  hold_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk_i(clk), .reset_i(rst), .req0_i(req0), .req1_i(req1), .hlda_i(hlda),
    .hold_o(hold_o), .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .owner_o(owner_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic hold, g0, g1, own, err;
    int   ph;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  // Reference model: phase 0 idle, 1 waiting for HLDA, 2 bus granted, 3 handing back.
  int m_phase, m_owner, m_last, m_tenure;

  function void model_reset();
    m_phase = 0; m_owner = 0; m_last = 1; m_tenure = 0;
  endfunction

  function void model_step();
    logic r[2];
    exp_t e;
    logic err;
    r[0] = req0; r[1] = req1; err = 1'b0;
    case (m_phase)
      0: if (r[0] || r[1]) begin
           if (r[0] && r[1]) m_owner = 1 - m_last;
           else              m_owner = r[1] ? 1 : 0;
           m_phase = 1;
         end
      1: if (!r[m_owner]) m_phase = 3;
         else if (hlda) begin m_phase = 2; m_tenure = 0; end
      2: begin
           m_tenure++;
           if (!hlda) begin m_phase = 0; err = 1'b1; end
           else if (!r[m_owner]) m_phase = 3;
           else if (m_tenure > MAXH && r[1 - m_owner]) m_phase = 3;
         end
      default: if (!hlda) begin m_last = m_owner; m_phase = 0; end
    endcase
    e.hold = (m_phase == 1 || m_phase == 2);
    e.g0   = (m_phase == 2 && m_owner == 0);
    e.g1   = (m_phase == 2 && m_owner == 1);
    e.own  = m_owner[0];
    e.err  = err;
    e.ph   = m_phase;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (hold,gnt0,gnt1,owner,err) t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expected output vector per clock, owner ignored in idle.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en && exp_q.size() > 0) begin
        exp_t e;
        logic [4:0] got, want, mask;
        e    = exp_q.pop_front();
        got  = {hold_o, gnt0_o, gnt1_o, owner_o, err_o};
        want = {e.hold, e.g0, e.g1, e.own, e.err};
        mask = (e.ph != 0) ? 5'b11111 : 5'b11101;
        n_cmp++;
        if (((got ^ want) & mask) != 5'b0) begin
          n_bad++;
          $display("FAIL cycle: got %b expected %b mask %b (hold,gnt0,gnt1,owner,err) t=%0t",
                   got, want, mask, $time);
        end
      end
    end
  end

  // Behavioural 8088: answers HOLD changes after a programmable delay.
  int   dly = 0, dmin = 0, dmax = 0;
  logic prev_hold = 1'b0;
  bit   inject = 1'b0, err_rand = 1'b0;

  task automatic cycle(input logic r0, input logic r1);
    @(negedge clk);
    req0 = r0; req1 = r1;
    if (err_rand && !inject && $urandom_range(0, 39) == 0) inject = 1'b1;
    if (hold_o !== prev_hold) begin
      dly = $urandom_range(dmax, dmin);
      prev_hold = hold_o;
    end
    if (inject && (gnt0_o || gnt1_o)) begin
      hlda = 1'b0;
      inject = 1'b0;
    end else if (hold_o && !hlda) begin
      if (dly == 0) hlda = 1'b1; else dly--;
    end else if (!hold_o && hlda) begin
      if (dly == 0) hlda = 1'b0; else dly--;
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic drive(input logic r0, input logic r1, input int n);
    for (int i = 0; i < n; i++) cycle(r0, r1);
  endtask

  task automatic apply_reset();
    @(negedge clk); #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset", {hold_o, gnt0_o, gnt1_o, 2'b00}, 5'b00000);
    req0 = 1'b0; req1 = 1'b0; hlda = 1'b0; prev_hold = 1'b0; inject = 1'b0;
    @(posedge clk); @(negedge clk);
    check("reset_state", {hold_o, gnt0_o, gnt1_o, owner_o, err_o}, 5'b00000);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    mon_en = 1'b1;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Single requester, HLDA lags HOLD.
    dmin = 1; dmax = 1;
    drive(1, 0, 8);
    drive(0, 0, 6);

    // Contention from reset: requester 0 first, preempted, then requester 1.
    apply_reset();
    dmin = 0; dmax = 0;
    drive(1, 1, 20);
    drive(0, 0, 6);

    // Lone requester is never preempted.
    drive(0, 1, 50);
    drive(0, 0, 6);

    // Withdraw before a slow HLDA arrives.
    dmin = 5; dmax = 5;
    drive(1, 0, 2);
    drive(0, 0, 14);

    // HLDA lost during GRANT; same requester must win again.
    apply_reset();
    dmin = 0; dmax = 0;
    drive(1, 1, 3);
    inject = 1'b1;
    drive(1, 1, 12);
    drive(0, 0, 6);

    // Asynchronous reset while granted.
    drive(1, 0, 6);
    apply_reset();
    drive(0, 0, 2);

    // Random traffic with occasional HLDA loss.
    dmin = 0; dmax = 3; err_rand = 1'b1;
    for (int k = 0; k < 60; k++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    err_rand = 1'b0; inject = 1'b0;
    drive(0, 0, 10);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
